// File: rtl/lelo_temp_pkg.sv
// lelo_temp_pkg: shared definitions for the lelo temperature-sensor sequencer.
// Holds the default sizing constants, the sequencer state type and a helper
// that returns how many clk edges separate a start edge from the cycle in
// which result_valid is high.
`timescale 1ns/1ps
package lelo_temp_pkg;

    localparam int LELO_CNT_W         = 11;
    localparam int LELO_WIN_W         = 8;
    localparam int LELO_AVG_LOG2      = 2;
    localparam int LELO_WARM_CYCLES   = 2;
    localparam int LELO_SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_STOP    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } lelo_temp_state_t;

    // A window length of zero behaves as one cycle.
    function automatic int lelo_temp_latency(input int avg_log2, input int warm,
                                             input int win, input int settle);
        int win_eff;
        win_eff = (win == 0) ? 1 : win;
        return (1 << avg_log2) * (warm + win_eff + settle + 1) + 1;
    endfunction

endpackage

// File: rtl/lelo_temp_avg.sv
// lelo_temp_avg: window accumulator for the temperature sequencer.
// Sums one captured count per window, tracks which window of the current
// result is being captured and remembers whether any window read all-ones.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         restart accumulation for a new result
//   add         add din to the sum and advance the window index
//   din         captured oscillator count
//   mean        sum divided by 2^AVG_LOG2 (truncating)
//   sat_acc     at least one window of this result read all-ones
//   last        current window is the final one of the result
`timescale 1ns/1ps
module lelo_temp_avg
    import lelo_temp_pkg::*;
#(
    parameter int CNT_W    = LELO_CNT_W,
    parameter int AVG_LOG2 = LELO_AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] mean,
    output logic             sat_acc,
    output logic             last
);

    // Two extra bits absorb the sum of 2^AVG_LOG2 full-scale counts.
    logic [CNT_W+AVG_LOG2-1:0] acc_r;
    logic [AVG_LOG2-1:0]       idx_r;
    logic                      sat_acc_r;

    // Accumulator, window index and saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= '0;
            idx_r     <= '0;
            sat_acc_r <= 1'b0;
        end else if (clr) begin
            acc_r     <= '0;
            idx_r     <= '0;
            sat_acc_r <= 1'b0;
        end else if (add) begin
            acc_r <= acc_r + {{AVG_LOG2{1'b0}}, din};
            if (din == {CNT_W{1'b1}}) begin
                sat_acc_r <= 1'b1;
            end
            if (!last) begin
                idx_r <= idx_r + 1'b1;
            end
        end
    end

    assign last    = (idx_r == {AVG_LOG2{1'b1}});
    assign mean    = acc_r[CNT_W+AVG_LOG2-1:AVG_LOG2];
    assign sat_acc = sat_acc_r;

endmodule

// File: rtl/lelo_temp_seq.sv
// lelo_temp_seq: measurement sequencer for the lelo temperature sensor.
// Per window: warm the ring oscillator with its counter held clear, let it
// count for the latched window length, stop it, wait for the count to settle,
// then capture. 2^AVG_LOG2 windows are averaged into one result.
// Ports:
//   clk, rst_n    32768 Hz clock, asynchronous active-low reset
//   start         request one result (accepted only when idle)
//   continuous    restart automatically after each result
//   abort         return to idle at the next edge, overrides everything
//   win_len       window length in clk cycles, 0 acts as 1
//   cnt_in        oscillator counter, stable while osc_en is low
//   osc_en        oscillator enable
//   cnt_clr       oscillator counter clear
//   busy          sequencer not idle
//   result        averaged count, held between results
//   result_valid  one-cycle pulse when result updates
//   sat           some window of the last result read all-ones
`timescale 1ns/1ps
module lelo_temp_seq
    import lelo_temp_pkg::*;
#(
    parameter int CNT_W         = LELO_CNT_W,
    parameter int WIN_W         = LELO_WIN_W,
    parameter int AVG_LOG2      = LELO_AVG_LOG2,
    parameter int WARM_CYCLES   = LELO_WARM_CYCLES,
    parameter int SETTLE_CYCLES = LELO_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             sat
);

    // Timer holds "cycles remaining minus one" for the current phase.
    localparam logic [WIN_W-1:0] WARM_LOAD   = WIN_W'(WARM_CYCLES - 1);
    localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);

    lelo_temp_state_t state_r, state_nx_s;
    logic [WIN_W-1:0] timer_r, timer_nx_s;
    logic [WIN_W-1:0] win_lat_r;
    logic [WIN_W-1:0] win_load_s;
    logic [CNT_W-1:0] result_r;
    logic             result_valid_r;
    logic             sat_r;
    logic             avg_clr_s, avg_add_s, latch_s, done_s;
    logic [CNT_W-1:0] avg_mean_s;
    logic             avg_sat_s, avg_last_s;

    assign win_load_s = (win_lat_r == '0) ? '0 : (win_lat_r - 1'b1);

    lelo_temp_avg #(
        .CNT_W    (CNT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (avg_clr_s),
        .add     (avg_add_s),
        .din     (cnt_in),
        .mean    (avg_mean_s),
        .sat_acc (avg_sat_s),
        .last    (avg_last_s)
    );

    // Next-state, phase timer and accumulator control.
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        avg_clr_s  = 1'b0;
        avg_add_s  = 1'b0;
        latch_s    = 1'b0;
        done_s     = 1'b0;
        if (abort) begin
            state_nx_s = ST_IDLE;
            timer_nx_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s = ST_WARMUP;
                        timer_nx_s = WARM_LOAD;
                        avg_clr_s  = 1'b1;
                        latch_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (timer_r == '0) begin
                        state_nx_s = ST_MEASURE;
                        timer_nx_s = win_load_s;
                    end else begin
                        timer_nx_s = timer_r - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (timer_r == '0) begin
                        state_nx_s = ST_STOP;
                        timer_nx_s = SETTLE_LOAD;
                    end else begin
                        timer_nx_s = timer_r - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer_r == '0) begin
                        state_nx_s = ST_CAPTURE;
                    end else begin
                        timer_nx_s = timer_r - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    avg_add_s = 1'b1;
                    if (avg_last_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_WARMUP;
                        timer_nx_s = WARM_LOAD;
                    end
                end
                ST_DONE: begin
                    done_s = 1'b1;
                    if (continuous) begin
                        state_nx_s = ST_WARMUP;
                        timer_nx_s = WARM_LOAD;
                        avg_clr_s  = 1'b1;
                        latch_s    = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    timer_nx_s = '0;
                end
            endcase
        end
    end

    // State, timer, latched window length and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            timer_r        <= '0;
            win_lat_r      <= '0;
            result_r       <= '0;
            sat_r          <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            timer_r        <= timer_nx_s;
            result_valid_r <= done_s;
            if (latch_s) begin
                win_lat_r <= win_len;
            end
            if (done_s) begin
                result_r <= avg_mean_s;
                sat_r    <= avg_sat_s;
            end
        end
    end

    assign osc_en       = (state_r == ST_WARMUP) || (state_r == ST_MEASURE);
    assign cnt_clr      = (state_r == ST_IDLE) || (state_r == ST_WARMUP);
    assign busy         = (state_r != ST_IDLE);
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign sat          = sat_r;

endmodule

// File: tb/tb_lelo_temp_seq.sv
// tb_lelo_temp_seq: self-checking bench for lelo_temp_seq. An oscillator
// counter model adds a per-window increment each cycle the oscillator runs;
// expected results come from a window-level reference (count = inc * window,
// clamped at full scale, averaged over four windows).
`timescale 1ns/1ps
module tb_lelo_temp_seq;
    import lelo_temp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  win_len = 8'd0;
    logic [10:0] cnt_in;
    logic        osc_en, cnt_clr, busy, result_valid, sat;
    logic [10:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    // Oscillator counter model state.
    int inc_tab [4];
    int cnt_m = 0;
    int fall_cnt = 0;
    int base = 0;
    int nxt;

    typedef struct {
        int win;
        int i0, i1, i2, i3;
        int exp_res;
        int exp_sat;
        int exp_lat;
    } vec_t;

    vec_t tbl [5];

    lelo_temp_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .win_len      (win_len),
        .cnt_in       (cnt_in),
        .osc_en       (osc_en),
        .cnt_clr      (cnt_clr),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    // Each falling edge of osc_en ends one window.
    always @(negedge osc_en) fall_cnt <= fall_cnt + 1;

    // Counter: cleared by cnt_clr, counts while enabled, clamps at full scale.
    always @(posedge clk) begin
        if (cnt_clr) begin
            cnt_m <= 0;
        end else if (osc_en) begin
            nxt = cnt_m + inc_tab[(fall_cnt - base) & 3];
            cnt_m <= (nxt > 2047) ? 2047 : nxt;
        end
    end
    assign cnt_in = cnt_m[10:0];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Window-level reference for one result.
    task automatic model(input int win, input int i0, input int i1, input int i2,
                         input int i3, output int res, output int s, output int lat);
        int incs [4];
        int weff, v, sum;
        incs[0] = i0; incs[1] = i1; incs[2] = i2; incs[3] = i3;
        weff = (win == 0) ? 1 : win;
        sum = 0;
        s = 0;
        for (int w = 0; w < 4; w++) begin
            v = incs[w] * weff;
            if (v > 2047) v = 2047;
            if (v == 2047) s = 1;
            sum += v;
        end
        res = sum >> 2;
        lat = 4 * (2 + weff + 2 + 1) + 1;
    endtask

    // One start-to-result run with checks on latency, value, sat and handshake.
    task automatic run_check(input string tag, input int win, input int i0, input int i1,
                             input int i2, input int i3, input int e_res,
                             input int e_sat, input int e_lat);
        int lat, res, s, bz;
        inc_tab[0] = i0; inc_tab[1] = i1; inc_tab[2] = i2; inc_tab[3] = i3;
        base = fall_cnt;
        win_len = win[7:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        win_len = 8'($urandom_range(0, 255));
        lat = -1; res = -1; s = -1; bz = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = n; res = result; s = sat; bz = busy;
                break;
            end
        end
        chk({tag, "/latency"}, lat, e_lat);
        chk({tag, "/result"}, res, e_res);
        chk({tag, "/sat"}, s, e_sat);
        chk({tag, "/busy_after"}, bz, 0);
        @(posedge clk);
        #1;
        chk({tag, "/valid_one_cycle"}, result_valid, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int r_res, r_sat, r_lat, w, a, b, c, d;
        int pulses [$];

        tbl[0] = '{4, 25, 25, 25, 25, 100, 0, 37};
        tbl[1] = '{1, 25, 26, 27, 29, 26, 0, 25};
        tbl[2] = '{0, 25, 25, 25, 25, 25, 0, 25};
        tbl[3] = '{4, 25, 600, 25, 25, 586, 1, 37};
        tbl[4] = '{4, 25, 25, 25, 25, 100, 0, 37};
        inc_tab[0] = 0; inc_tab[1] = 0; inc_tab[2] = 0; inc_tab[3] = 0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst/osc_en", osc_en, 0);
        chk("rst/cnt_clr", cnt_clr, 1);
        chk("rst/busy", busy, 0);
        chk("rst/result", result, 0);
        chk("rst/result_valid", result_valid, 0);
        chk("rst/sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors.
        for (int k = 0; k < 5; k++) begin
            run_check($sformatf("vec%0d", k), tbl[k].win, tbl[k].i0, tbl[k].i1,
                      tbl[k].i2, tbl[k].i3, tbl[k].exp_res, tbl[k].exp_sat, tbl[k].exp_lat);
        end

        // Randomized runs against the reference.
        for (int k = 0; k < 6; k++) begin
            w = $urandom_range(0, 12);
            a = $urandom_range(0, 700); b = $urandom_range(0, 700);
            c = $urandom_range(0, 700); d = $urandom_range(0, 700);
            model(w, a, b, c, d, r_res, r_sat, r_lat);
            run_check($sformatf("rnd%0d", k), w, a, b, c, d, r_res, r_sat, r_lat);
        end

        // Continuous mode, dropped during the third result; start while busy.
        inc_tab[0] = 25; inc_tab[1] = 25; inc_tab[2] = 25; inc_tab[3] = 25;
        base = fall_cnt;
        continuous = 1'b1;
        win_len = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                pulses.push_back(n);
                chk($sformatf("cont/result@%0d", n), result, 100);
            end
            start = (n == 50 || n == 90) ? 1'b1 : 1'b0;
            if (n == 80) continuous = 1'b0;
        end
        chk("cont/pulse_count", pulses.size(), 3);
        if (pulses.size() >= 3) begin
            chk("cont/first", pulses[0], 37);
            chk("cont/gap1", pulses[1] - pulses[0], 37);
            chk("cont/gap2", pulses[2] - pulses[1], 37);
        end else begin
            chk("cont/pulses_missing", pulses.size(), 3);
        end
        chk("cont/idle_end", busy, 0);

        // Abort during MEASURE of the third window.
        base = fall_cnt;
        win_len = 8'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("abort/in_measure", osc_en, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort/osc_en", osc_en, 0);
        chk("abort/cnt_clr", cnt_clr, 1);
        chk("abort/busy", busy, 0);
        r_res = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (result_valid) r_res++;
        end
        chk("abort/no_valid", r_res, 0);
        chk("abort/result_held", result, 100);

        // Asynchronous reset mid-MEASURE.
        base = fall_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst/osc_en", osc_en, 0);
        chk("arst/cnt_clr", cnt_clr, 1);
        chk("arst/busy", busy, 0);
        chk("arst/result", result, 0);
        chk("arst/result_valid", result_valid, 0);
        chk("arst/sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
